// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// default datapath width. Fetch, execute and the control FSM import this too.
package decode_writeback_pkg;

   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned NREGS      = 15;

   typedef enum logic [3:0] {
      IHALT   = 4'h0,
      INOP    = 4'h1,
      IRRMOVQ = 4'h2,
      IIRMOVQ = 4'h3,
      IRMMOVQ = 4'h4,
      IMRMOVQ = 4'h5,
      IOPQ    = 4'h6,
      IJXX    = 4'h7,
      ICALL   = 4'h8,
      IRET    = 4'h9,
      IPUSHQ  = 4'hA,
      IPOPQ   = 4'hB
   } icode_e;

   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file with two registered read ports and two write ports
// (E and M). M wins when both target the same register. Reads see the
// pre-write contents; there is no bypass.
module y86_regfile
   import decode_writeback_pkg::*;
#(
   parameter int unsigned         DATA_W    = DEF_DATA_W,
   parameter logic [DATA_W-1:0]   RSP_RESET = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [3:0]        src_a,
   input  logic [3:0]        src_b,
   input  logic              wr_en,
   input  logic [3:0]        dst_e,
   input  logic [3:0]        dst_m,
   input  logic [DATA_W-1:0] val_e,
   input  logic [DATA_W-1:0] val_m,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] rd_a_q, rd_a_d;
   logic [DATA_W-1:0] rd_b_q, rd_b_d;

   // Next-state: read ports sample old contents, then E and M writes (M last).
   // RNONE (0xF) matches no entry, so reads of it give 0 and writes are dropped.
   always_comb begin
      regs_d = regs_q;
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (rd_en) begin
         rd_a_d = '0;
         rd_b_d = '0;
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (src_a == 4'(i)) rd_a_d = regs_q[i];
            if (src_b == 4'(i)) rd_b_d = regs_q[i];
         end
      end
      if (wr_en) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (dst_e == 4'(i)) regs_d[i] = val_e;
            if (dst_m == 4'(i)) regs_d[i] = val_m;
         end
      end
   end

   // State register with synchronous reset; %rsp gets its reset value.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
         regs_q[RRSP] <= RSP_RESET;
         rd_a_q       <= '0;
         rd_b_q       <= '0;
      end else begin
         regs_q <= regs_d;
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_a = rd_a_q;
   assign rd_b = rd_b_q;

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: selects source and destination registers
// from icode/rA/rB/Cnd and drives the register file.
module decode_writeback
   import decode_writeback_pkg::*;
#(
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read_enable,
   input  logic              write_enable,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              Cnd,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB
);

   logic [3:0] src_a, src_b, dst_e, dst_m;

   // Register selection by instruction class; unknown icodes select RNONE.
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode)
         IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
         IRET, IPOPQ:                    src_a = RRSP;
         default: ;
      endcase
      case (icode)
         IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
         ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
         default: ;
      endcase
      case (icode)
         IRRMOVQ:                        dst_e = Cnd ? rB : RNONE;
         IIRMOVQ, IOPQ:                  dst_e = rB;
         ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RRSP;
         default: ;
      endcase
      case (icode)
         IMRMOVQ, IPOPQ:                 dst_m = rA;
         default: ;
      endcase
   end

   y86_regfile #(
      .DATA_W    (DATA_W),
      .RSP_RESET (RSP_RESET)
   ) u_regfile (
      .clock (clock),
      .reset (reset),
      .rd_en (read_enable),
      .src_a (src_a),
      .src_b (src_b),
      .wr_en (write_enable),
      .dst_e (dst_e),
      .dst_m (dst_m),
      .val_e (valE),
      .val_m (valM),
      .rd_a  (valA),
      .rd_b  (valB)
   );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus a
// randomized run against a behavioural register-file model.
module tb_decode_writeback;

   localparam int unsigned DW   = 64;
   localparam logic [63:0] RSPR = 64'h100;

   logic          clock = 1'b0;
   logic          reset, read_enable, write_enable, Cnd;
   logic [3:0]    icode, rA, rB;
   logic [DW-1:0] valE, valM, valA, valB;

   logic [DW-1:0] m_r [15];
   logic [DW-1:0] m_a, m_b;
   int            n_checks = 0;
   int            n_fail   = 0;

   decode_writeback #(
      .DATA_W    (DW),
      .RSP_RESET (RSPR)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .icode        (icode),
      .rA           (rA),
      .rB           (rB),
      .Cnd          (Cnd),
      .valE         (valE),
      .valM         (valM),
      .valA         (valA),
      .valB         (valB)
   );

   always #5 clock = ~clock;

   // Instruction-class rules (icode values as plain numbers).
   function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic == 4'h2) return c ? rb : 4'hF;
      if (ic inside {4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [3:0] r);
      if (r == 4'hF) return '0;
      return m_r[r];
   endfunction

   // Apply one edge of stimulus and advance the model; outputs settle #1 later.
   task automatic step(input logic re, input logic we, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb, input logic c,
                       input logic [DW-1:0] ve, input logic [DW-1:0] vm);
      logic [3:0] de, dm;
      read_enable  = re;
      write_enable = we;
      icode = ic; rA = ra; rB = rb; Cnd = c; valE = ve; valM = vm;
      if (re) begin
         m_a = m_read(f_src_a(ic, ra));
         m_b = m_read(f_src_b(ic, rb));
      end
      if (we) begin
         de = f_dst_e(ic, rb, c);
         dm = f_dst_m(ic, ra);
         if (de != 4'hF) m_r[de] = ve;
         if (dm != 4'hF) m_r[dm] = vm;
      end
      @(posedge clock);
      #1;
      read_enable  = 1'b0;
      write_enable = 1'b0;
   endtask

   // Decode as OPq so that valA=R[ra], valB=R[rb].
   task automatic peek(input logic [3:0] ra, input logic [3:0] rb);
      step(1'b1, 1'b0, 4'h6, ra, rb, 1'b0, '0, '0);
   endtask

   // Reset edge with a writeback strobe also asserted; the write must be ignored.
   task automatic do_reset();
      reset = 1'b1; write_enable = 1'b1; read_enable = 1'b1;
      icode = 4'h3; rA = 4'hF; rB = 4'h2; Cnd = 1'b0; valE = 64'hAA; valM = 64'hBB;
      @(posedge clock);
      #1;
      reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
      for (int i = 0; i < 15; i++) m_r[i] = '0;
      m_r[4] = RSPR;
      m_a = '0;
      m_b = '0;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h55, '0);
      peek(4'h2, 4'h2);
      do_reset();
      n_checks++;
      if (valA !== '0) begin n_fail++; $display("FAIL reset_valA actual=%h required=0", valA); end
      n_checks++;
      if (valB !== '0) begin n_fail++; $display("FAIL reset_valB actual=%h required=0", valB); end
      step(1'b1, 1'b0, 4'hA, 4'h0, 4'hF, 1'b0, '0, '0);
      n_checks++;
      if (valA !== 64'h0) begin n_fail++; $display("FAIL pushq_valA actual=%h required=0", valA); end
      n_checks++;
      if (valB !== 64'h100) begin n_fail++; $display("FAIL pushq_valB_rsp actual=%h required=100", valB); end
      peek(4'h2, 4'h3);
      n_checks++;
      if (valA !== 64'h0) begin n_fail++; $display("FAIL reset_blocks_write actual=%h required=0", valA); end
   endtask

   task automatic test_irmovq_rrmovq();
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, '0);
      step(1'b1, 1'b0, 4'h2, 4'h2, 4'hF, 1'b0, '0, '0);
      n_checks++;
      if (valA !== 64'h1234) begin n_fail++; $display("FAIL rrmovq_valA actual=%h required=1234", valA); end
      n_checks++;
      if (valB !== 64'h0) begin n_fail++; $display("FAIL rrmovq_valB_rnone actual=%h required=0", valB); end
   endtask

   task automatic test_cmov();
      step(1'b0, 1'b1, 4'h2, 4'hF, 4'h3, 1'b0, 64'h5, '0);
      peek(4'h3, 4'h3);
      n_checks++;
      if (valA !== 64'h0) begin n_fail++; $display("FAIL cmov_cnd0 actual=%h required=0", valA); end
      step(1'b0, 1'b1, 4'h2, 4'hF, 4'h3, 1'b1, 64'h5, '0);
      peek(4'h3, 4'h3);
      n_checks++;
      if (valB !== 64'h5) begin n_fail++; $display("FAIL cmov_cnd1 actual=%h required=5", valB); end
   endtask

   task automatic test_popq();
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h200, '0);
      step(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hDEAD);
      peek(4'h4, 4'h4);
      n_checks++;
      if (valA !== 64'hDEAD) begin n_fail++; $display("FAIL popq_rsp_m_wins actual=%h required=dead", valA); end
      step(1'b0, 1'b1, 4'hB, 4'h1, 4'hF, 1'b0, 64'h210, 64'h77);
      peek(4'h1, 4'h4);
      n_checks++;
      if (valA !== 64'h77) begin n_fail++; $display("FAIL popq_r1_valM actual=%h required=77", valA); end
      n_checks++;
      if (valB !== 64'h210) begin n_fail++; $display("FAIL popq_rsp_valE actual=%h required=210", valB); end
   endtask

   task automatic test_hold();
      peek(4'h1, 4'h4);
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h999, '0);
      n_checks++;
      if (valA !== 64'h77 || valB !== 64'h210) begin
         n_fail++; $display("FAIL hold_after_wb actual=%h/%h required=77/210", valA, valB);
      end
      step(1'b0, 1'b0, 4'h3, 4'hF, 4'h1, 1'b0, 64'h444, '0);
      n_checks++;
      if (valA !== 64'h77 || valB !== 64'h210) begin
         n_fail++; $display("FAIL hold_idle actual=%h/%h required=77/210", valA, valB);
      end
      peek(4'h1, 4'h1);
      n_checks++;
      if (valA !== 64'h999) begin n_fail++; $display("FAIL idle_no_write actual=%h required=999", valA); end
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h5555, '0);
      for (int r = 0; r < 15; r++) begin
         peek(4'(r), 4'(r));
         n_checks++;
         if (valA !== m_r[r]) begin
            n_fail++; $display("FAIL rnone_write_dropped r%0d actual=%h required=%h", r, valA, m_r[r]);
         end
      end
   endtask

   task automatic test_same_edge();
      step(1'b0, 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h7, '0);
      step(1'b1, 1'b1, 4'h6, 4'h5, 4'h5, 1'b0, 64'h9, '0);
      n_checks++;
      if (valA !== 64'h7 || valB !== 64'h7) begin
         n_fail++; $display("FAIL same_edge_old_value actual=%h/%h required=7/7", valA, valB);
      end
      peek(4'h5, 4'h5);
      n_checks++;
      if (valA !== 64'h9) begin n_fail++; $display("FAIL same_edge_written actual=%h required=9", valA); end
   endtask

   task automatic test_random();
      logic [3:0]    ic, ra, rb;
      logic [DW-1:0] ve, vm;
      for (int n = 0; n < 400; n++) begin
         ic = 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         rb = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         ve = {$urandom, $urandom};
         vm = {$urandom, $urandom};
         step(1'($urandom), 1'($urandom), ic, ra, rb, 1'($urandom), ve, vm);
         n_checks++;
         if (valA !== m_a || valB !== m_b) begin
            n_fail++;
            $display("FAIL random_%0d ic=%h rA=%h rB=%h actual=%h/%h required=%h/%h",
                     n, ic, ra, rb, valA, valB, m_a, m_b);
         end
      end
      for (int r = 0; r < 15; r++) begin
         peek(4'(r), 4'hF);
         n_checks++;
         if (valA !== m_r[r]) begin
            n_fail++; $display("FAIL random_final r%0d actual=%h required=%h", r, valA, m_r[r]);
         end
      end
   endtask

   initial begin
      reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
      icode = '0; rA = '0; rB = '0; Cnd = 1'b0; valE = '0; valM = '0;
      #2;
      do_reset();
      test_reset();
      test_irmovq_rrmovq();
      test_cmov();
      test_popq();
      test_hold();
      test_same_edge();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
